// File: rtl/pps_pkg.sv
// Shared types and helpers for the PPS time-of-day counter.
package pps_pkg;

  // Lock-quality state of the PPS tracker.
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } pps_state_t;

  // Width of the cycle counters: must hold values up to 2*F inclusive.
  function automatic int cnt_width(input int freq);
    return $clog2(2 * freq + 1);
  endfunction

endpackage

// File: rtl/pps_interval_meter.sv
// Measures the cycle count between PPS pulses and classifies each pulse
// as good/bad, and flags the cycle in which an expected pulse is overdue.
module pps_interval_meter
  import pps_pkg::*;
#(
  parameter int  C_CLOCK_FREQUENCY = 125000,
  parameter int  C_TOLERANCE       = 16,
  localparam int W                 = cnt_width(C_CLOCK_FREQUENCY)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_pps,
  input  pps_state_t   i_state,
  output logic [W-1:0] o_cnt,
  output logic         o_sat,
  output logic         o_good,
  output logic         o_missing
);

  localparam logic [W-1:0] C_SAT = W'(2 * C_CLOCK_FREQUENCY);
  localparam logic [W-1:0] C_LO  = W'(C_CLOCK_FREQUENCY - C_TOLERANCE);
  localparam logic [W-1:0] C_HI  = W'(C_CLOCK_FREQUENCY + C_TOLERANCE);

  logic [W-1:0] r_cnt;
  logic         w_sat;

  // Interval counter: restarts at 1 after each pulse, saturates at 2F.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous and takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_pps) begin
      r_cnt <= W'(1);
    end else if (r_cnt != C_SAT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_sat     = (r_cnt == C_SAT);
  assign o_cnt     = r_cnt;
  assign o_sat     = w_sat;
  // A pulse is only judged once we have a reference edge (state != UNLOCKED).
  assign o_good    = (i_state != UNLOCKED) && !w_sat &&
                     (r_cnt >= C_LO) && (r_cnt <= C_HI);
  // cnt restarts on every pulse that enters ACQUIRE/LOCKED, so it always
  // passes through F+T exactly once when the pulse fails to show up.
  assign o_missing = ((i_state == ACQUIRE) || (i_state == LOCKED)) &&
                     !i_pps && (r_cnt == C_HI);

endmodule

// File: rtl/pps_tod_counter.sv
// Time-of-day counter disciplined by a single-cycle PPS pulse: keeps
// seconds and sub-second cycles, tracks lock quality and free-runs in
// holdover when the pulse disappears.
module pps_tod_counter
  import pps_pkg::*;
#(
  parameter int  C_CLOCK_FREQUENCY = 125000,
  parameter int  C_TOLERANCE       = 16,
  parameter int  C_LOCK_COUNT      = 3,
  parameter int  C_HOLDOVER_SEC    = 4,
  localparam int W                 = cnt_width(C_CLOCK_FREQUENCY)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pps,
  input  logic         sec_set_valid,
  input  logic [31:0]  sec_set_value,
  output logic [31:0]  tod_sec,
  output logic [W-1:0] tod_subsec,
  output logic [W-1:0] pps_period,
  output logic         period_valid,
  output logic         locked,
  output logic         holdover,
  output logic         pps_missing
);

  localparam int GW = $clog2(C_LOCK_COUNT + 1);
  localparam int HW = $clog2(C_HOLDOVER_SEC + 1);

  localparam logic [W-1:0]  C_LAST    = W'(C_CLOCK_FREQUENCY - 1);
  localparam logic [W-1:0]  C_TOL     = W'(C_TOLERANCE);
  localparam logic [W-1:0]  C_HOLD_HI = W'(C_CLOCK_FREQUENCY - 1 - C_TOLERANCE);
  localparam logic [GW-1:0] C_GOOD_LAST = GW'(C_LOCK_COUNT - 1);
  localparam logic [HW-1:0] C_HO_LAST   = HW'(C_HOLDOVER_SEC - 1);

  pps_state_t    r_state;
  logic [GW-1:0] r_good_cnt;
  logic [HW-1:0] r_ho_cnt;
  logic [31:0]   r_sec;
  logic [W-1:0]  r_subsec;
  logic [31:0]   r_pending;
  logic          r_pending_valid;
  logic [W-1:0]  r_period;
  logic          r_period_valid;
  logic          r_missing;

  logic [W-1:0]  w_cnt;
  logic          w_sat;
  logic          w_good;
  logic          w_missing;
  logic          w_rollover;
  logic          w_advance;
  logic [31:0]   w_next_sec;
  logic          w_period_upd;
  logic          w_ho_aligned;

  pps_interval_meter #(
    .C_CLOCK_FREQUENCY (C_CLOCK_FREQUENCY),
    .C_TOLERANCE       (C_TOLERANCE)
  ) u_meter (
    .clk       (clk),
    .rst       (rst),
    .i_pps     (pps),
    .i_state   (r_state),
    .o_cnt     (w_cnt),
    .o_sat     (w_sat),
    .o_good    (w_good),
    .o_missing (w_missing)
  );

  // Internal second boundary; a pulse in the same cycle owns the boundary.
  assign w_rollover   = !pps && (r_subsec == C_LAST);
  // A pulse landing within T of a boundary is late and already counted.
  assign w_advance    = pps ? (r_subsec > C_TOL) : (w_missing || w_rollover);
  // An incoming set beats the pending one so a coincident load is honoured.
  assign w_next_sec   = sec_set_valid   ? sec_set_value :
                        r_pending_valid ? r_pending     : r_sec + 32'd1;
  assign w_period_upd = pps && (r_state != UNLOCKED) && !w_sat;
  assign w_ho_aligned = (r_subsec <= C_TOL) || (r_subsec >= C_HOLD_HI);

  // Seconds, sub-second and pending-load registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sec           <= '0;
      r_subsec        <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
    end else begin
      if (pps)             r_subsec <= '0;
      else if (w_missing)  r_subsec <= C_TOL;
      else if (w_rollover) r_subsec <= '0;
      else                 r_subsec <= r_subsec + 1'b1;

      if (w_advance) begin
        r_sec           <= w_next_sec;
        r_pending_valid <= 1'b0;
      end else if (sec_set_valid) begin
        r_pending       <= sec_set_value;
        r_pending_valid <= 1'b1;
      end
    end
  end

  // Period measurement strobe for every judged pulse, good or bad.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period       <= '0;
      r_period_valid <= 1'b0;
    end else begin
      r_period_valid <= w_period_upd;
      if (w_period_upd) r_period <= w_cnt;
    end
  end

  // Lock-quality state machine with good-pulse and holdover counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= UNLOCKED;
      r_good_cnt <= '0;
      r_ho_cnt   <= '0;
      r_missing  <= 1'b0;
    end else begin
      r_missing <= w_missing;
      case (r_state)
        UNLOCKED: begin
          if (pps) begin
            r_state    <= ACQUIRE;
            r_good_cnt <= '0;
          end
        end
        ACQUIRE: begin
          if (pps) begin
            if (w_good) begin
              r_good_cnt <= r_good_cnt + 1'b1;
              if (r_good_cnt == C_GOOD_LAST) r_state <= LOCKED;
            end else begin
              r_good_cnt <= '0;
            end
          end else if (w_missing) begin
            r_state <= UNLOCKED;
          end
        end
        LOCKED: begin
          if (pps) begin
            if (!w_good) begin
              r_state    <= ACQUIRE;
              r_good_cnt <= '0;
            end
          end else if (w_missing) begin
            r_state  <= HOLDOVER;
            r_ho_cnt <= '0;
          end
        end
        HOLDOVER: begin
          if (pps) begin
            if (w_ho_aligned) begin
              r_state <= LOCKED;
            end else begin
              r_state    <= ACQUIRE;
              r_good_cnt <= '0;
            end
          end else if (w_rollover) begin
            r_ho_cnt <= r_ho_cnt + 1'b1;
            if (r_ho_cnt == C_HO_LAST) r_state <= UNLOCKED;
          end
        end
        default: r_state <= UNLOCKED;
      endcase
    end
  end

  assign tod_sec      = r_sec;
  assign tod_subsec   = r_subsec;
  assign pps_period   = r_period;
  assign period_valid = r_period_valid;
  assign locked       = (r_state == LOCKED);
  assign holdover     = (r_state == HOLDOVER);
  assign pps_missing  = r_missing;

endmodule

// File: tb/tb_pps_tod_counter.sv
// Directed bench for pps_tod_counter with a shortened second (F=100, T=8)
// so that lock, holdover and expiry sequences run in a few thousand cycles.
module tb_pps_tod_counter;

  localparam int F  = 100;
  localparam int T  = 8;
  localparam int LC = 3;
  localparam int HS = 4;
  localparam int W  = $clog2(2 * F + 1);

  logic         clk = 1'b0;
  logic         rst;
  logic         pps;
  logic         sec_set_valid;
  logic [31:0]  sec_set_value;
  logic [31:0]  tod_sec;
  logic [W-1:0] tod_subsec;
  logic [W-1:0] pps_period;
  logic         period_valid;
  logic         locked;
  logic         holdover;
  logic         pps_missing;

  int checks    = 0;
  int errors    = 0;
  int n_missing = 0;

  pps_tod_counter #(
    .C_CLOCK_FREQUENCY (F),
    .C_TOLERANCE       (T),
    .C_LOCK_COUNT      (LC),
    .C_HOLDOVER_SEC    (HS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pps           (pps),
    .sec_set_valid (sec_set_valid),
    .sec_set_value (sec_set_value),
    .tod_sec       (tod_sec),
    .tod_subsec    (tod_subsec),
    .pps_period    (pps_period),
    .period_valid  (period_valid),
    .locked        (locked),
    .holdover      (holdover),
    .pps_missing   (pps_missing)
  );

  always #5 clk = ~clk;

  // One vector: idle cycles, then a pulse; expected outputs one cycle later.
  typedef struct {
    int          idle;
    logic [31:0] sec;
    int          period;
    logic        pv;
    logic        lk;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic step(input logic p, input logic sv, input logic [31:0] val);
    pps           = p;
    sec_set_valid = sv;
    sec_set_value = val;
    @(posedge clk);
    #1;
    pps           = 1'b0;
    sec_set_valid = 1'b0;
    if (pps_missing) n_missing++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sec"},    tod_sec,      0);
    check({tag, "_subsec"}, tod_subsec,   0);
    check({tag, "_period"}, pps_period,   0);
    check({tag, "_pv"},     period_valid, 0);
    check({tag, "_locked"}, locked,       0);
    check({tag, "_hold"},   holdover,     0);
    check({tag, "_miss"},   pps_missing,  0);
  endtask

  initial begin
    // idle, sec, period, period_valid, locked
    vecs[0]  = '{20,  1,   0, 1'b0, 1'b0};  // first pulse: UNLOCKED->ACQUIRE
    vecs[1]  = '{99,  2, 100, 1'b1, 1'b0};
    vecs[2]  = '{99,  3, 100, 1'b1, 1'b0};
    vecs[3]  = '{99,  4, 100, 1'b1, 1'b1};  // 4th pulse locks
    vecs[4]  = '{99,  5, 100, 1'b1, 1'b1};
    vecs[5]  = '{104, 6, 105, 1'b1, 1'b1};  // late but good, no extra advance
    vecs[6]  = '{94,  7,  95, 1'b1, 1'b1};  // early but good
    vecs[7]  = '{119, 10, 120, 1'b1, 1'b0}; // via holdover (+rollover +missing)
    vecs[8]  = '{99,  11, 100, 1'b1, 1'b0};
    vecs[9]  = '{99,  12, 100, 1'b1, 1'b0};
    vecs[10] = '{99,  13, 100, 1'b1, 1'b1}; // relocked after three good
    vecs[11] = '{89,  14,  90, 1'b1, 1'b0}; // early bad drops to ACQUIRE
    vecs[12] = '{99,  15, 100, 1'b1, 1'b0};
    vecs[13] = '{90,  16,  91, 1'b1, 1'b0}; // bad in ACQUIRE clears good count
    vecs[14] = '{99,  17, 100, 1'b1, 1'b0};
    vecs[15] = '{99,  18, 100, 1'b1, 1'b0};
    vecs[16] = '{99,  19, 100, 1'b1, 1'b1};
    vecs[17] = '{107, 20, 108, 1'b1, 1'b1}; // exactly F+T is still good
    vecs[18] = '{91,  21,  92, 1'b1, 1'b1}; // exactly F-T is still good

    rst           = 1'b1;
    pps           = 1'b0;
    sec_set_valid = 1'b0;
    sec_set_value = '0;
    idle(3);
    check_zero("reset");
    rst = 1'b0;

    // Table-driven pulse train.
    for (int v = 0; v < 19; v++) begin
      idle(vecs[v].idle);
      step(1'b1, 1'b0, 32'd0);
      check($sformatf("v%0d_sec", v),    tod_sec,      vecs[v].sec);
      check($sformatf("v%0d_subsec", v), tod_subsec,   0);
      check($sformatf("v%0d_period", v), pps_period,   vecs[v].period);
      check($sformatf("v%0d_pv", v),     period_valid, vecs[v].pv);
      check($sformatf("v%0d_locked", v), locked,       vecs[v].lk);
      check($sformatf("v%0d_hold", v),   holdover,     0);
    end

    // Holdover entry, then recovery at subsec == T after an internal rollover.
    idle(108);
    check("hb_miss",   pps_missing, 1);
    check("hb_hold",   holdover,    1);
    check("hb_locked", locked,      0);
    check("hb_subsec", tod_subsec,  T);
    check("hb_sec",    tod_sec,     23);
    idle(1);
    check("hb_miss_off", pps_missing, 0);
    idle(99);
    step(1'b1, 1'b0, 32'd0);
    check("hb_rec_sec",    tod_sec,      24);
    check("hb_rec_subsec", tod_subsec,   0);
    check("hb_rec_locked", locked,       1);
    check("hb_rec_hold",   holdover,     0);
    check("hb_rec_pv",     period_valid, 0);
    check("hb_rec_period", pps_period,   92);

    // Holdover expiry after four internal rollovers.
    idle(108);
    check("ha_miss",   pps_missing, 1);
    check("ha_hold",   holdover,    1);
    check("ha_sec",    tod_sec,     26);
    check("ha_subsec", tod_subsec,  T);
    n_missing = 0;
    idle(92);
    check("ha_sec_r1",    tod_sec,    27);
    check("ha_subsec_r1", tod_subsec, 0);
    idle(299);
    check("ha_hold_last", holdover,   1);
    check("ha_sec_last",  tod_sec,    29);
    check("ha_sub_last",  tod_subsec, F - 1);
    idle(1);
    check("ha_hold_end",   holdover,   0);
    check("ha_locked_end", locked,     0);
    check("ha_sec_end",    tod_sec,    30);
    check("ha_subsec_end", tod_subsec, 0);
    check("ha_no_repeat_miss", n_missing, 0);

    // Seconds load: mid-second set, then a coincident set with the pulse.
    idle(19);
    step(1'b1, 1'b0, 32'd0);
    check("set_pre_sec", tod_sec,      31);
    check("set_pre_pv",  period_valid, 0);
    idle(49);
    step(1'b0, 1'b1, 32'd1000);
    check("set_hold_sec", tod_sec, 31);
    idle(49);
    step(1'b1, 1'b0, 32'd0);
    check("set_load_sec", tod_sec, 1000);
    idle(99);
    step(1'b1, 1'b0, 32'd0);
    check("set_next_sec", tod_sec, 1001);
    idle(99);
    step(1'b1, 1'b1, 32'd2000);
    check("set_coinc_sec", tod_sec, 2000);
    check("set_coinc_lk",  locked,  1);
    idle(20);
    step(1'b0, 1'b1, 32'd500);
    idle(20);
    step(1'b0, 1'b1, 32'd600);
    idle(57);
    step(1'b1, 1'b0, 32'd0);
    check("set_overwrite_sec", tod_sec, 600);
    idle(99);
    step(1'b1, 1'b0, 32'd0);
    check("set_cleared_sec", tod_sec, 601);

    // Mid-second reset with a coincident pulse, then re-acquisition.
    idle(50);
    rst = 1'b1;
    step(1'b1, 1'b0, 32'd0);
    rst = 1'b0;
    check_zero("midrst");
    idle(29);
    step(1'b1, 1'b0, 32'd0);
    check("rr_sec",    tod_sec,      1);
    check("rr_pv",     period_valid, 0);
    check("rr_period", pps_period,   0);
    check("rr_locked", locked,       0);
    idle(99);
    step(1'b1, 1'b0, 32'd0);
    check("rr2_sec",    tod_sec,      2);
    check("rr2_pv",     period_valid, 1);
    check("rr2_period", pps_period,   100);

    // Missing pulse while acquiring falls back to UNLOCKED, not holdover.
    idle(108);
    check("am_miss",   pps_missing, 1);
    check("am_hold",   holdover,    0);
    check("am_locked", locked,      0);
    check("am_sec",    tod_sec,     4);
    check("am_subsec", tod_subsec,  T);
    idle(1);
    check("am_miss_off", pps_missing, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pps_tod_counter.md
# pps_tod_counter

Time-of-day counter that consumes the single-cycle `pps_out` pulse produced by `pps_receiver` and keeps seconds plus sub-second (clock-cycle) time in the fabric clock domain. It measures each PPS interval against the nominal clock frequency and tracks lock quality. When PPS is lost it free-runs in holdover. Its outputs feed timestamping and scheduling logic.

## Interface
- `C_CLOCK_FREQUENCY`, 125000, nominal clk cycles per second (F); F > 2*C_TOLERANCE+2
- `C_TOLERANCE`, 16, accepted interval error in cycles (T)
- `C_LOCK_COUNT`, 3, consecutive good intervals needed to lock (≥1)
- `C_HOLDOVER_SEC`, 4, internal second rollovers tolerated in holdover before unlocking (≥1)
- W = $clog2(2*F+1), width of cycle counters
- `clk`  in  1  core clock; one clock; reset is synchronous and active-high
- `rst`  in  1  synchronous active-high reset
- `pps`  in  1  single-cycle PPS pulse (from `pps_receiver.pps_out`)
- `sec_set_valid`  in  1  load request for seconds value
- `sec_set_value`  in  32  seconds value for the next second boundary
- `tod_sec`  out  32  seconds
- `tod_subsec`  out  W  cycles since last second boundary
- `pps_period`  out  W  last measured PPS interval in cycles
- `period_valid`  out  1  one-cycle strobe, `pps_period` updated
- `locked`  out  1  state == LOCKED
- `holdover`  out  1  state == HOLDOVER
- `pps_missing`  out  1  one-cycle strobe, expected PPS not seen

## Operation
- Interval counter `cnt`: set to 1 in the cycle after any `pps`, else increments, saturating at 2F. At a pps cycle, `cnt` equals the cycles since the previous pps.
- Good pulse: state ≠ UNLOCKED, `cnt` not saturated, and |cnt − F| ≤ T.
- ToD, all states:
  - On `pps`: subsec←0. sec advances unless subsec ≤ T, because a late pulse already rolled over internally.
  - Without `pps`: subsec == F−1 gives subsec←0 and a sec advance. Otherwise subsec+1.
  - Missing event: subsec←T and a sec advance.
- A sec advance loads the pending set value if one is pending, else sec+1.
  - `sec_set_valid` writes the pending register; a later set overwrites it.
  - When set and advance occur in the same cycle, the incoming value is used.
- States (enum in package):
  - UNLOCKED: on pps → ACQUIRE, good_cnt←0.
  - ACQUIRE:
    - good pps → good_cnt+1; reaching C_LOCK_COUNT → LOCKED.
    - bad pps → good_cnt←0.
    - cnt reaches F+T with no pps → `pps_missing`, UNLOCKED.
  - LOCKED:
    - good pps → stay.
    - bad pps → ACQUIRE, good_cnt←0.
    - cnt reaches F+T → `pps_missing`, HOLDOVER, ho_cnt←0.
  - HOLDOVER:
    - pps with subsec ≤ T or subsec ≥ F−1−T → LOCKED.
    - Any other pps → ACQUIRE.
    - Each internal rollover increments ho_cnt; reaching C_HOLDOVER_SEC → UNLOCKED.
- `period_valid`/`pps_period`: updated for every pps while state ≠ UNLOCKED and cnt is not saturated, good or bad.

## Timing
- Reset values: state UNLOCKED, cnt 0, tod_sec 0, tod_subsec 0, pps_period 0, no pending set, all strobes and flags 0.
- `rst` mid-operation returns every register to its reset value on the next edge. A pps coincident with rst is ignored.
- All outputs are registered.
  - pps at cycle t → tod_subsec=0, `period_valid`=1, and the new state/flags at t+1.
  - `pps_missing` is high at cycle t0+F+T+1 for a pps at t0.
- `pps_missing` fires only on the LOCKED/ACQUIRE exit, never repeatedly in HOLDOVER.
- Simultaneous pps and internal rollover: one sec advance only.

## Structure
- Package `pps_pkg`:
  - state enum `pps_state_t` (UNLOCKED, ACQUIRE, LOCKED, HOLDOVER)
  - width function for W
- Sub-module `pps_interval_meter`: the cnt counter, saturation, and the good/bad and missing decisions.
- The top level holds the FSM and ToD registers.

## Test plan
All scenarios use F=125000, T=16, LOCK_COUNT=3, HOLDOVER_SEC=4.
- Reset then pps every 125000 cycles: locked=1 one cycle after the 4th pulse; pps_period=125000; tod_sec increments by 1 per pulse.
- Locked, then one interval of 125040: pps_period=125040, state ACQUIRE, locked=0; three further good intervals relock.
- Locked, pps stops: `pps_missing` at t0+125017.
  - Check tod_subsec=16 after the missing event and a seconds advance every 125000 cycles.
  - After the 4th internal rollover, holdover drops and state is UNLOCKED.
- Holdover, pps returns 10 cycles after an internal rollover: no extra sec increment, tod_subsec←0, locked=1.
- `sec_set_value`=1000 pulsed mid-second: the next pps gives tod_sec=1000 and the following one 1001; a coincident set and pps also yields the set value.
- Assert rst mid-second while locked: all outputs are 0 next cycle; the next pps enters ACQUIRE with no period_valid.
